// File: rtl/johnson_pkg.sv
// Shared constants for the Johnson phase tracker: phase count, the legal
// 4-bit Johnson codes in phase order, tracker state encoding and a helper.
package johnson_pkg;

  localparam int unsigned PHASES = 8;

  // Legal codes {q3,q2,q1,q0}, listed in phase-index order 0..7.
  localparam logic [3:0] CODE_P0 = 4'b0000;
  localparam logic [3:0] CODE_P1 = 4'b0001;
  localparam logic [3:0] CODE_P2 = 4'b0011;
  localparam logic [3:0] CODE_P3 = 4'b0111;
  localparam logic [3:0] CODE_P4 = 4'b1111;
  localparam logic [3:0] CODE_P5 = 4'b1110;
  localparam logic [3:0] CODE_P6 = 4'b1100;
  localparam logic [3:0] CODE_P7 = 4'b1000;

  // Tracker state encoding; LOCKED doubles as the lock indicator bit.
  localparam logic [0:0] ST_SYNC   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // One-hot expansion of a 3-bit phase index.
  function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code decoder: maps a 4-bit code to its phase
// index and flags whether the code belongs to the legal 8-state set.
module johnson_code_decode
  import johnson_pkg::*;
(
  input  logic [3:0] q,
  output logic [2:0] idx,
  output logic       legal
);

  // Table lookup of the eight legal codes; anything else is illegal.
  always_comb begin
    idx   = 3'd0;
    legal = 1'b1;
    case (q)
      CODE_P0: idx = 3'd0;
      CODE_P1: idx = 3'd1;
      CODE_P2: idx = 3'd2;
      CODE_P3: idx = 3'd3;
      CODE_P4: idx = 3'd4;
      CODE_P5: idx = 3'd5;
      CODE_P6: idx = 3'd6;
      CODE_P7: idx = 3'd7;
      default: begin
        idx   = 3'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Johnson phase tracker: decodes the upstream Johnson counter, checks the
// code sequence, locks after LOCK_CNT consecutive successors, counts
// revolutions while locked and reports illegal codes / sequence breaks.
module johnson_phase_tracker
  import johnson_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned REV_W      = 8,
  parameter int unsigned ALLOW_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       q,
  input  logic             clr_err,
  output logic [2:0]       phase_idx,
  output logic [7:0]       phase_oh,
  output logic             locked,
  output logic             wrap,
  output logic [REV_W-1:0] rev_cnt,
  output logic             illegal,
  output logic             seq_err,
  output logic             err_sticky
);

  localparam logic [3:0] LOCK_CNT_C   = 4'(LOCK_CNT);
  localparam logic       ALLOW_HOLD_C = (ALLOW_HOLD != 0);

  logic [2:0]       dec_idx_s;
  logic             dec_legal_s;
  logic [2:0]       succ_idx_s;
  logic             is_succ_s;
  logic             is_hold_s;
  logic [4:0]       cnt_inc_s;

  logic [0:0]       state_r,      state_s;
  logic [3:0]       cnt_r,        cnt_s;
  logic             prev_valid_r, prev_valid_s;
  logic [2:0]       phase_idx_r,  phase_idx_s;
  logic [7:0]       phase_oh_r,   phase_oh_s;
  logic             wrap_r,       wrap_s;
  logic [REV_W-1:0] rev_cnt_r,    rev_cnt_s;
  logic             illegal_r,    illegal_s;
  logic             seq_err_r,    seq_err_s;
  logic             err_sticky_r, err_sticky_s;

  johnson_code_decode u_decode (
    .q     (q),
    .idx   (dec_idx_s),
    .legal (dec_legal_s)
  );

  // Successor/hold classification against the stored reference phase.
  always_comb begin
    succ_idx_s = phase_idx_r + 3'd1;
    is_succ_s  = (dec_idx_s == succ_idx_s);
    is_hold_s  = (dec_idx_s == phase_idx_r);
    cnt_inc_s  = {1'b0, cnt_r} + 5'd1;
  end

  // Next-state logic for sequence tracking, lock, revolutions and errors.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    prev_valid_s = prev_valid_r;
    phase_idx_s  = phase_idx_r;
    phase_oh_s   = phase_oh_r;
    rev_cnt_s    = rev_cnt_r;
    wrap_s       = 1'b0;
    illegal_s    = 1'b0;
    seq_err_s    = 1'b0;

    if (en) begin
      if (!dec_legal_s) begin
        // Illegal code: drop lock and reference, keep last good index.
        illegal_s    = 1'b1;
        phase_oh_s   = 8'd0;
        state_s      = ST_SYNC;
        cnt_s        = 4'd0;
        prev_valid_s = 1'b0;
      end else if (!prev_valid_r) begin
        // First legal code after reset/illegal only sets the reference.
        phase_idx_s  = dec_idx_s;
        phase_oh_s   = idx_to_onehot(dec_idx_s);
        prev_valid_s = 1'b1;
        cnt_s        = 4'd0;
        state_s      = ST_SYNC;
      end else if (is_hold_s && ALLOW_HOLD_C) begin
        // Tolerated repeat: nothing changes.
        state_s = state_r;
      end else if (is_succ_s) begin
        phase_idx_s = dec_idx_s;
        phase_oh_s  = idx_to_onehot(dec_idx_s);
        case (state_r)
          ST_SYNC: begin
            if (cnt_inc_s >= {1'b0, LOCK_CNT_C}) begin
              cnt_s   = LOCK_CNT_C;
              state_s = ST_LOCKED;
            end else begin
              cnt_s = cnt_inc_s[3:0];
            end
          end
          ST_LOCKED: begin
            if (phase_idx_r == 3'd7) begin
              wrap_s    = 1'b1;
              rev_cnt_s = rev_cnt_r + REV_W'(1);
            end else begin
              wrap_s = 1'b0;
            end
          end
          default: begin
            state_s = ST_SYNC;
            cnt_s   = 4'd0;
          end
        endcase
      end else begin
        // Legal but out of sequence: restart from the new reference.
        phase_idx_s = dec_idx_s;
        phase_oh_s  = idx_to_onehot(dec_idx_s);
        seq_err_s   = (state_r == ST_LOCKED);
        state_s     = ST_SYNC;
        cnt_s       = 4'd0;
      end
    end else begin
      state_s = state_r;
    end

    // A new error on the same edge as clr_err keeps the flag set.
    if (illegal_s || seq_err_s) begin
      err_sticky_s = 1'b1;
    end else if (clr_err) begin
      err_sticky_s = 1'b0;
    end else begin
      err_sticky_s = err_sticky_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_SYNC;
      cnt_r        <= 4'd0;
      prev_valid_r <= 1'b0;
      phase_idx_r  <= 3'd0;
      phase_oh_r   <= 8'd0;
      wrap_r       <= 1'b0;
      rev_cnt_r    <= '0;
      illegal_r    <= 1'b0;
      seq_err_r    <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      prev_valid_r <= prev_valid_s;
      phase_idx_r  <= phase_idx_s;
      phase_oh_r   <= phase_oh_s;
      wrap_r       <= wrap_s;
      rev_cnt_r    <= rev_cnt_s;
      illegal_r    <= illegal_s;
      seq_err_r    <= seq_err_s;
      err_sticky_r <= err_sticky_s;
    end
  end

  assign phase_idx  = phase_idx_r;
  assign phase_oh   = phase_oh_r;
  assign locked     = (state_r == ST_LOCKED);
  assign wrap       = wrap_r;
  assign rev_cnt    = rev_cnt_r;
  assign illegal    = illegal_r;
  assign seq_err    = seq_err_r;
  assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Directed testbench for johnson_phase_tracker. Two instances share the
// stimulus: dut0 with ALLOW_HOLD=0, dut1 with ALLOW_HOLD=1.
module tb_johnson_phase_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] q;
  logic       clr_err;

  logic [2:0] idx0, idx1;
  logic [7:0] oh0, oh1;
  logic       lk0, lk1, wr0, wr1, il0, il1, se0, se1, es0, es1;
  logic [7:0] rc0, rc1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

  johnson_phase_tracker #(.LOCK_CNT(4), .REV_W(8), .ALLOW_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .q(q), .clr_err(clr_err),
    .phase_idx(idx0), .phase_oh(oh0), .locked(lk0), .wrap(wr0),
    .rev_cnt(rc0), .illegal(il0), .seq_err(se0), .err_sticky(es0)
  );

  johnson_phase_tracker #(.LOCK_CNT(4), .REV_W(8), .ALLOW_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .q(q), .clr_err(clr_err),
    .phase_idx(idx1), .phase_oh(oh1), .locked(lk1), .wrap(wr1),
    .rev_cnt(rc1), .illegal(il1), .seq_err(se1), .err_sticky(es1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one enabled sample and settle just after the edge.
  task automatic step(input logic [3:0] code);
    q  = code;
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; q = 4'b0000; clr_err = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_idx", {29'd0, idx0}, 32'd0);
    check_eq("rst_oh", {24'd0, oh0}, 32'd0);
    check_eq("rst_lock", {31'd0, lk0}, 32'd0);
    check_eq("rst_rev", {24'd0, rc0}, 32'd0);
    check_eq("rst_err", {31'd0, es0}, 32'd0);
    rst = 1'b0;

    // Free-running counter from 0000: lock on 5th, wraps on 9th and 17th.
    for (int s = 1; s <= 17; s++) begin
      step(codes[(s - 1) % 8]);
      if (s == 1) check_eq("first_oh", {24'd0, oh0}, 32'h01);
      if (s == 1) check_eq("first_lock", {31'd0, lk0}, 32'd0);
      if (s == 4) check_eq("s4_lock", {31'd0, lk0}, 32'd0);
      if (s == 5) check_eq("s5_lock", {31'd0, lk0}, 32'd1);
      if (s == 5) check_eq("s5_idx", {29'd0, idx0}, 32'd4);
      if (s == 8) check_eq("s8_wrap", {31'd0, wr0}, 32'd0);
      if (s == 9) check_eq("s9_wrap", {31'd0, wr0}, 32'd1);
      if (s == 9) check_eq("s9_rev", {24'd0, rc0}, 32'd1);
      if (s == 10) check_eq("s10_wrap", {31'd0, wr0}, 32'd0);
      if (s == 17) check_eq("s17_rev", {24'd0, rc0}, 32'd2);
    end
    check_eq("run_err", {31'd0, es0}, 32'd0);

    // Illegal code while locked, then resume and relock.
    step(4'b0101);
    check_eq("ill_pulse", {31'd0, il0}, 32'd1);
    check_eq("ill_oh", {24'd0, oh0}, 32'd0);
    check_eq("ill_lock", {31'd0, lk0}, 32'd0);
    check_eq("ill_sticky", {31'd0, es0}, 32'd1);
    check_eq("ill_idx_hold", {29'd0, idx0}, 32'd0);
    step(4'b0001);
    check_eq("res_ill", {31'd0, il0}, 32'd0);
    check_eq("res_oh", {24'd0, oh0}, 32'h02);
    step(4'b0011); step(4'b0111); step(4'b1111);
    check_eq("res3_lock", {31'd0, lk0}, 32'd0);
    step(4'b1110);
    check_eq("res4_lock", {31'd0, lk0}, 32'd1);
    check_eq("res_rev", {24'd0, rc0}, 32'd2);

    // Advance to idx 2 while locked (7->0 wraps to rev 3).
    step(4'b1100); step(4'b1000); step(4'b0000);
    check_eq("wrap3_rev", {24'd0, rc0}, 32'd3);
    step(4'b0001); step(4'b0011);

    // Sequence break 2 -> 6 while locked, then relock.
    step(4'b1100);
    check_eq("brk_seq", {31'd0, se0}, 32'd1);
    check_eq("brk_lock", {31'd0, lk0}, 32'd0);
    check_eq("brk_idx", {29'd0, idx0}, 32'd6);
    step(4'b1000);
    check_eq("brk_seq_clr", {31'd0, se0}, 32'd0);
    step(4'b0000);
    check_eq("sync_nowrap", {31'd0, wr0}, 32'd0);
    check_eq("sync_rev", {24'd0, rc0}, 32'd3);
    step(4'b0001);
    check_eq("brk3_lock", {31'd0, lk0}, 32'd0);
    step(4'b0011);
    check_eq("brk4_lock", {31'd0, lk0}, 32'd1);

    // Hold: 0111 then two repeats.
    step(4'b0111);
    step(4'b0111);
    check_eq("hold0_seq", {31'd0, se0}, 32'd1);
    check_eq("hold0_lock", {31'd0, lk0}, 32'd0);
    check_eq("hold1_seq", {31'd0, se1}, 32'd0);
    check_eq("hold1_lock", {31'd0, lk1}, 32'd1);
    step(4'b0111);
    check_eq("hold0_seq2", {31'd0, se0}, 32'd0);
    check_eq("hold1_lock2", {31'd0, lk1}, 32'd1);
    check_eq("hold1_idx", {29'd0, idx1}, 32'd3);

    // clr_err together with an illegal sample: set wins; then clear alone.
    clr_err = 1'b1;
    step(4'b0101);
    check_eq("clr_vs_ill", {31'd0, es0}, 32'd1);
    step(4'b0000);
    check_eq("clr_alone", {31'd0, es0}, 32'd0);
    clr_err = 1'b0;

    // Run to locked with rev_cnt = 5.
    for (int s = 1; s <= 16; s++) begin
      step(codes[s % 8]);
    end
    check_eq("pre_rev5", {24'd0, rc0}, 32'd5);
    check_eq("pre_lock", {31'd0, lk0}, 32'd1);
    check_eq("pre_idx", {29'd0, idx0}, 32'd0);

    // en=0: no sampling while q changes.
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      q = (c == 0) ? 4'b0101 : ((c == 1) ? 4'b1111 : 4'b0011);
      @(posedge clk); #1;
      check_eq("en0_idx", {29'd0, idx0}, 32'd0);
      check_eq("en0_lock", {31'd0, lk0}, 32'd1);
      check_eq("en0_pulses", {29'd0, il0, se0, wr0}, 32'd0);
      check_eq("en0_rev", {24'd0, rc0}, 32'd5);
    end

    // Reset while locked clears everything on that edge.
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mrst_lock", {31'd0, lk0}, 32'd0);
    check_eq("mrst_rev", {24'd0, rc0}, 32'd0);
    check_eq("mrst_idx", {29'd0, idx0}, 32'd0);
    check_eq("mrst_oh", {24'd0, oh0}, 32'd0);
    check_eq("mrst_err1", {31'd0, es1}, 32'd0);
    check_eq("mrst_lock1", {31'd0, lk1}, 32'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
